// File: rtl/pes_lcd_msg_seq_if.sv
// pes_lcd_msg_seq_if -- bundle of host/controller signals for pes_lcd_msg_seq.
//   Host side     : WR_EN, WR_ADDR[4:0], WR_DATA[7:0] (buffer writes), START.
//   Controller    : RDY in, DATA[7:0], OPER[1:0], ENB out.
//   Status        : BUSY, DONE, dbg_state[2:0] (current FSM state, for checkers).
// Handshake: ENB is a one-cycle strobe raised only after RDY=1 was seen; after
// each ENB the sequencer ignores RDY for one cycle, then waits for RDY=1 again
// before presenting the next byte.  DATA/OPER are stable whenever ENB=1.
interface pes_lcd_msg_seq_if;
    logic       WR_EN;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       START;
    logic       RDY;
    logic [7:0] DATA;
    logic [1:0] OPER;
    logic       ENB;
    logic       BUSY;
    logic       DONE;
    logic [2:0] dbg_state;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, START, RDY,
        input  DATA, OPER, ENB, BUSY, DONE, dbg_state
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, START, RDY,
        output DATA, OPER, ENB, BUSY, DONE, dbg_state
    );
endinterface

// File: rtl/pes_lcd_msg_seq.sv
// pes_lcd_msg_seq -- feeds a character LCD controller from a 32-byte text buffer.
// After reset it sends the 4-command init sequence, then idles.  START sends a
// full refresh: cmd 0x80, 16 line-1 chars, cmd 0xC0, 16 line-2 chars.
//   CLK, RST : clock, synchronous active-high reset.
//   bus      : pes_lcd_msg_seq_if.slave (buffer writes, START, RDY/ENB/DATA/OPER,
//              BUSY, DONE, dbg_state).
// One step counter covers both sequences: steps 0-3 are init, 4-37 refresh.
module pes_lcd_msg_seq (
    input  logic               CLK,
    input  logic               RST,
    pes_lcd_msg_seq_if.slave   bus
);
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;

    localparam logic [5:0] STEP_INIT_LAST = 6'd3;
    localparam logic [5:0] STEP_REF_FIRST = 6'd4;
    localparam logic [5:0] STEP_LINE2_CMD = 6'd21;
    localparam logic [5:0] STEP_REF_LAST  = 6'd37;

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_CHAR = 2'b01;

    logic [2:0] state_q, state_d;
    logic [5:0] step_q, step_d;
    logic       pend_q, pend_d;
    logic       done_q, done_d;
    logic [7:0] data_q, data_d;
    logic [1:0] oper_q, oper_d;
    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];

    logic [7:0] seq_byte;
    logic [1:0] seq_oper;
    logic [4:0] rd_idx;
    logic       pend_in;

    // Buffer writes are accepted in every state.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.WR_EN) begin
            mem_d[bus.WR_ADDR] = bus.WR_DATA;
        end
    end

    // Byte for the current step.  Reads the registered buffer, so a write
    // landing on the same edge as the LOAD sample is not seen.
    always_comb begin
        seq_byte = 8'h00;
        seq_oper = OP_CMD;
        rd_idx   = 5'd0;
        if (step_q <= STEP_INIT_LAST) begin
            case (step_q[1:0])
                2'd0:    seq_byte = 8'h38;
                2'd1:    seq_byte = 8'h0C;
                2'd2:    seq_byte = 8'h01;
                default: seq_byte = 8'h06;
            endcase
        end else if (step_q == STEP_REF_FIRST) begin
            seq_byte = 8'h80;
        end else if (step_q == STEP_LINE2_CMD) begin
            seq_byte = 8'hC0;
        end else begin
            // Steps 5-20 map to buffer 0-15, steps 22-37 to buffer 16-31.
            rd_idx   = (step_q < STEP_LINE2_CMD) ? 5'(step_q - 6'd5) : 5'(step_q - 6'd6);
            seq_byte = mem_q[rd_idx];
            seq_oper = OP_CHAR;
        end
    end

    // A START seen while busy (including this cycle) is folded into pend_in so
    // it can be consumed by a completion happening on the same edge.
    assign pend_in = pend_q | (bus.START & (state_q != ST_IDLE));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pend_d  = pend_in;
        done_d  = 1'b0;
        data_d  = data_q;
        oper_d  = oper_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_LOAD;
                step_d  = 6'd0;
            end
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_LOAD;
                    step_d  = STEP_REF_FIRST;
                end
            end
            ST_LOAD: begin
                data_d = seq_byte;
                oper_d = seq_oper;
                if (bus.RDY) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_GAP;
            // RDY is ignored here: the controller needs a cycle to drop it.
            ST_GAP:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.RDY) begin
                    if (step_q == STEP_INIT_LAST || step_q == STEP_REF_LAST) begin
                        done_d = (step_q == STEP_REF_LAST);
                        if (pend_in) begin
                            state_d = ST_LOAD;
                            step_d  = STEP_REF_FIRST;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_LOAD;
                        step_d  = step_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            step_q  <= 6'd0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            oper_q  <= OP_CMD;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'h20;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            data_q  <= data_d;
            oper_q  <= oper_d;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.DATA      = data_q;
    assign bus.OPER      = oper_q;
    assign bus.ENB       = (state_q == ST_ISSUE);
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.DONE      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/pes_lcd_msg_seq.md
PES_LCD_MSG_SEQ -- requirements
Module: pes_lcd_msg_seq

Interface
REQ-001: CLK  input  1  system clock; all state changes on rising edge.
REQ-002: RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003: WR_EN  input  1  host text-buffer write strobe.
REQ-004: WR_ADDR  input  5  buffer index (0-15 line 1, 16-31 line 2).
REQ-005: WR_DATA  input  8  character code to store.
REQ-006: START  input  1  single-cycle request to refresh the whole display from the buffer.
REQ-007: RDY  input  1  ready flag from the downstream pes_lcd controller (1 = idle, accepts ENB).
REQ-008: DATA  output  8  byte presented to the controller.
REQ-009: OPER  output  2  operation code: 2'b00 = command, 2'b01 = character data; other codes never driven.
REQ-010: ENB  output  1  single-cycle transfer strobe to the controller.
REQ-011: BUSY  output  1  high during the init sequence or a refresh.
REQ-012: DONE  output  1  one-cycle pulse when a refresh completes.

Function
REQ-013: Buffer holds 32 x 8-bit registers; WR_EN=1 writes WR_DATA to WR_ADDR at the clock edge, in any state.
REQ-014: States: INIT, IDLE, LOAD, ISSUE, GAP, WAIT; a step counter (0-37) selects the byte of the current sequence.
REQ-015: Init sequence: commands 0x38, 0x0C, 0x01, 0x06, in that order.
REQ-016: Refresh sequence, 34 transfers: command 0x80, buffer[0..15] as data, command 0xC0, buffer[16..31] as data.
REQ-017: LOAD: drives DATA/OPER for the current step, reading the buffer value registered at that edge, then goes to ISSUE only when RDY=1; otherwise stays in LOAD.
REQ-018: ISSUE: ENB=1 for exactly one cycle with DATA/OPER stable; next state GAP.
REQ-019: GAP: one cycle, RDY ignored (covers the controller's RDY deassertion latency); next state WAIT.
REQ-020: WAIT: stays until RDY=1, then advances the step counter; goes to LOAD if steps remain, else completes the sequence.
REQ-021: DATA/OPER hold their value from LOAD through WAIT; no change while ENB=1 or the controller is busy.
REQ-022: Init completion -> IDLE with no DONE pulse; refresh completion -> IDLE with DONE=1 for one cycle.
REQ-023: START in IDLE -> LOAD at step 0 of the refresh sequence on the next cycle; BUSY=1 from that cycle.
REQ-024: START while BUSY sets a pending flag (multiple requests collapse to one); on refresh completion with pending set, DONE pulses and a new refresh begins the next cycle, BUSY staying 1.
REQ-025: START during INIT sets pending; the refresh begins immediately after init completes.
REQ-026: A write to an address not yet transferred is reflected in the current refresh; a write in the same cycle as that address's LOAD is not (old value sent).
REQ-027: Minimum time per transfer is 3 cycles (LOAD, ISSUE, GAP) plus the WAIT time.

Reset
REQ-028: RST=1 -> state INIT, step 0, pending 0, ENB=0, DONE=0, BUSY=1, DATA=8'h00, OPER=2'b00, all buffer entries 8'h20 (space).
REQ-029: RST overrides WR_EN and START in the same cycle.
REQ-030: RST asserted mid-transfer (any state) aborts the transfer immediately; ENB is 0 in the following cycle and the init sequence restarts from 0x38.

Verification
REQ-031: Release reset, with a controller model that holds RDY low for 5 cycles per transfer -> exactly 4 ENB pulses (DATA 0x38, 0x0C, 0x01, 0x06, OPER 00), then BUSY=0, no DONE.
REQ-032: Write "HELLO" to addresses 0-4, then pulse START -> 34 ENB pulses: 0x80 cmd, 0x48 0x45 0x4C 0x4C 0x4F then 11 x 0x20 data, 0xC0 cmd, 16 x 0x20 data; one DONE pulse; then BUSY=0.
REQ-033: Hold RDY=0 for 100 cycles during a refresh -> no ENB in that period and DATA/OPER unchanged; the sequence resumes when RDY rises.
REQ-034: Pulse START 3 times during a refresh -> exactly one extra refresh (68 data/cmd transfers total), 2 DONE pulses.
REQ-035: Write 0x41 to address 20 while the transfer at step 3 is in progress -> the line-2 5th character is sent as 0x41.
REQ-036: Assert RST during the ISSUE cycle of step 10 -> ENB=0 next cycle, buffer back to 0x20, the init sequence restarts from 0x38, no DONE pulse.
